axis_frame_arbiter: RTL and testbench

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

---
 rtl/axis_frame_arbiter.sv | 163 ++++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
// Round-robin arbiter that merges PORTS AXI-Stream inputs onto one output.
// Sources are switched only on frame boundaries, after the tlast beat has been
// accepted. The output side is one registered stage. Each frame boundary costs
// one arbitration cycle.
module axis_frame_arbiter #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
    input  logic [PORTS-1:0]            input_axis_tvalid,
    output logic [PORTS-1:0]            input_axis_tready,
    input  logic [PORTS-1:0]            input_axis_tlast,
    input  logic [PORTS-1:0]            input_axis_tuser,
    output logic [DATA_WIDTH-1:0]       output_axis_tdata,
    output logic                        output_axis_tvalid,
    input  logic                        output_axis_tready,
    output logic                        output_axis_tlast,
    output logic                        output_axis_tuser,
    output logic [$clog2(PORTS)-1:0]    grant,
    output logic                        grant_valid
);

    localparam int GW = $clog2(PORTS);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Arbitration state
    state_t                r_state;
    state_t                w_state_next;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         w_grant_next;
    logic                  r_grant_valid;
    logic                  w_grant_valid_next;
    logic [GW-1:0]         r_rr_ptr;
    logic [GW-1:0]         w_rr_ptr_next;

    // Round-robin search result
    logic                  w_sel_found;
    logic [GW-1:0]         w_sel_idx;
    logic [GW-1:0]         w_grant_inc;

    // Datapath
    logic [DATA_WIDTH-1:0] w_port_data [PORTS];
    logic [PORTS-1:0]      w_tready;
    logic                  w_out_ready;
    logic                  w_accept;

    // Output register
    logic [DATA_WIDTH-1:0] r_out_tdata;
    logic                  r_out_tvalid;
    logic                  r_out_tlast;
    logic                  r_out_tuser;

    // Split the packed input data bus into one lane per port
    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            w_port_data[i] = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Find the first requesting port, scanning upward from rr_ptr with wrap
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = r_rr_ptr;
        for (int k = 0; k < PORTS; k++) begin
            if (!w_sel_found && input_axis_tvalid[(int'(r_rr_ptr) + k) % PORTS]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = GW'((int'(r_rr_ptr) + k) % PORTS);
            end
        end
    end

    // The output slot can take a beat when it is empty or draining this cycle
    assign w_out_ready = ~r_out_tvalid | output_axis_tready;
    assign w_accept    = (r_state == ACTIVE) & input_axis_tvalid[r_grant] & w_out_ready;

    // Port after the current grant, wrapping for non-power-of-two PORTS
    assign w_grant_inc = (r_grant == GW'(PORTS - 1)) ? '0 : r_grant + GW'(1);

    // FSM next-state, grant bookkeeping and per-port ready
    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        w_state_next       = r_state;
        w_grant_next       = r_grant;
        w_grant_valid_next = r_grant_valid;
        w_rr_ptr_next      = r_rr_ptr;
        w_tready           = '0;
        case (r_state)
            IDLE: begin
                // Arbitration cycle: nobody is ready, grant holds its last value
                if (w_sel_found) begin
                    w_state_next       = ACTIVE;
                    w_grant_next       = w_sel_idx;
                    w_grant_valid_next = 1'b1;
                end
            end
            ACTIVE: begin
                // Only the granted port sees ready; a stalled source just waits here
                w_tready[r_grant] = w_out_ready;
                if (w_accept && input_axis_tlast[r_grant]) begin
                    w_state_next       = IDLE;
                    w_grant_valid_next = 1'b0;
                    w_rr_ptr_next      = w_grant_inc;
                end
            end
            default: begin
                w_state_next       = IDLE;
                w_grant_valid_next = 1'b0;
            end
        endcase
    end

    // FSM state and arbitration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples pre-edge values regardless of statement order.
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_grant_valid <= w_grant_valid_next;
            r_rr_ptr      <= w_rr_ptr_next;
        end
    end

    // Output register: load on accept, drop valid once drained, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data payload is reset as well, so the output bus
            // reads all-zero while reset is held rather than stale data.
            r_out_tdata  <= '0;
            r_out_tvalid <= 1'b0;
            r_out_tlast  <= 1'b0;
            r_out_tuser  <= 1'b0;
        end else if (w_accept) begin
            r_out_tdata  <= w_port_data[r_grant];
            r_out_tvalid <= 1'b1;
            r_out_tlast  <= input_axis_tlast[r_grant];
            r_out_tuser  <= input_axis_tuser[r_grant];
        end else if (output_axis_tready) begin
            r_out_tvalid <= 1'b0;
        end
    end

    assign input_axis_tready  = w_tready;
    assign output_axis_tdata  = r_out_tdata;
    assign output_axis_tvalid = r_out_tvalid;
    assign output_axis_tlast  = r_out_tlast;
    assign output_axis_tuser  = r_out_tuser;
    assign grant              = r_grant;
    assign grant_valid        = r_grant_valid;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Testbench for axis_frame_arbiter (PORTS=4, DATA_WIDTH=8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A cycle is the span between two rising edges.
module tb_axis_frame_arbiter;

    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int GW    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [PORTS*DW-1:0]   in_tdata;
    logic [PORTS-1:0]      in_tvalid;
    logic [PORTS-1:0]      in_tready;
    logic [PORTS-1:0]      in_tlast;
    logic [PORTS-1:0]      in_tuser;
    logic [DW-1:0]         out_tdata;
    logic                  out_tvalid;
    logic                  out_tready;
    logic                  out_tlast;
    logic                  out_tuser;
    logic [GW-1:0]         grant;
    logic                  grant_valid;

    always #5 clk = ~clk;

    axis_frame_arbiter #(
        .PORTS      (PORTS),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .input_axis_tdata   (in_tdata),
        .input_axis_tvalid  (in_tvalid),
        .input_axis_tready  (in_tready),
        .input_axis_tlast   (in_tlast),
        .input_axis_tuser   (in_tuser),
        .output_axis_tdata  (out_tdata),
        .output_axis_tvalid (out_tvalid),
        .output_axis_tready (out_tready),
        .output_axis_tlast  (out_tlast),
        .output_axis_tuser  (out_tuser),
        .grant              (grant),
        .grant_valid        (grant_valid)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One vector = inputs applied in a cycle plus outputs expected in that cycle
    typedef struct {
        logic        rst;       // pulse reset before this vector
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [3:0]  tu;
        logic [31:0] td;
        logic        ordy;
        logic [3:0]  e_tr;
        logic        e_ov;
        logic        e_chk;     // compare data/last/user
        logic [7:0]  e_d;
        logic        e_l;
        logic        e_u;
        logic [1:0]  e_g;
        logic        e_gv;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] tv, input logic [3:0] tl,
                                input logic [3:0] tu, input logic [31:0] td, input logic ordy,
                                input logic [3:0] e_tr, input logic e_ov, input logic e_chk,
                                input logic [7:0] e_d, input logic e_l, input logic e_u,
                                input logic [1:0] e_g, input logic e_gv);
        vec_t v;
        v.rst = rst; v.tv = tv; v.tl = tl; v.tu = tu; v.td = td; v.ordy = ordy;
        v.e_tr = e_tr; v.e_ov = e_ov; v.e_chk = e_chk; v.e_d = e_d; v.e_l = e_l;
        v.e_u = e_u; v.e_g = e_g; v.e_gv = e_gv;
        return v;
    endfunction

    task automatic clear_inputs();
        in_tdata   = '0;
        in_tvalid  = '0;
        in_tlast   = '0;
        in_tuser   = '0;
        out_tready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[$];
    logic [7:0]  bp_beats [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    logic [7:0]  rx_data[$];
    logic        rx_last[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  idx;
        bit  acc;
        bit  done;

        rst_n = 1'b0;
        clear_inputs();

        // Port 2 sends a 3-beat frame, sink always ready
        vecs.push_back(mk(1, 4'b0100, 4'b0000, 4'b0000, 32'h00A1_0000, 1, 4'b0000, 0, 1, 8'h00, 0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 32'h00A1_0000, 1, 4'b0100, 0, 1, 8'h00, 0, 0, 2'd2, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 32'h00A2_0000, 1, 4'b0100, 1, 1, 8'hA1, 0, 0, 2'd2, 1));
        vecs.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 32'h00A3_0000, 1, 4'b0100, 1, 1, 8'hA2, 0, 1, 2'd2, 1));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 1, 1, 8'hA3, 1, 0, 2'd2, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 2'd2, 0));
        vecs.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 2'd2, 0));
        // All four ports request 1-beat frames continuously: grants 0,1,2,3,0
        vecs.push_back(mk(1, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0000, 0, 1, 8'h00, 0, 0, 2'd0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0001, 0, 1, 8'h00, 0, 0, 2'd0, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0000, 1, 1, 8'h10, 1, 0, 2'd0, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0010, 0, 0, 8'h00, 0, 0, 2'd1, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0000, 1, 1, 8'h11, 1, 1, 2'd1, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0100, 0, 0, 8'h00, 0, 0, 2'd2, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0000, 1, 1, 8'h12, 1, 0, 2'd2, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b1000, 0, 0, 8'h00, 0, 0, 2'd3, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0000, 1, 1, 8'h13, 1, 1, 2'd3, 0));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0001, 0, 0, 8'h00, 0, 0, 2'd0, 1));
        vecs.push_back(mk(0, 4'b1111, 4'b1111, 4'b1010, 32'h1312_1110, 1, 4'b0000, 1, 1, 8'h10, 1, 0, 2'd0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            next_cycle();
            in_tvalid  = vecs[i].tv;
            in_tlast   = vecs[i].tl;
            in_tuser   = vecs[i].tu;
            in_tdata   = vecs[i].td;
            out_tready = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d tready", i), in_tready, vecs[i].e_tr);
            check($sformatf("vec%0d out_tvalid", i), out_tvalid, vecs[i].e_ov);
            check($sformatf("vec%0d grant", i), grant, vecs[i].e_g);
            check($sformatf("vec%0d grant_valid", i), grant_valid, vecs[i].e_gv);
            if (vecs[i].e_chk) begin
                check($sformatf("vec%0d out_tdata", i), out_tdata, vecs[i].e_d);
                check($sformatf("vec%0d out_tlast", i), out_tlast, vecs[i].e_l);
                check($sformatf("vec%0d out_tuser", i), out_tuser, vecs[i].e_u);
            end
        end

        // Sink backpressure for 5 cycles in the middle of a 4-beat frame on port 1
        do_reset();
        idx = 0;
        rx_data.delete();
        rx_last.delete();
        for (int cyc = 0; cyc < 20; cyc++) begin
            next_cycle();
            out_tready      = !(cyc >= 3 && cyc <= 7);
            in_tvalid[1]    = (idx < 4);
            in_tdata[15:8]  = (idx < 4) ? bp_beats[idx] : 8'h00;
            in_tlast[1]     = (idx == 3);
            @(negedge clk);
            acc = in_tready[1] && in_tvalid[1];
            if (out_tvalid && out_tready) begin
                rx_data.push_back(out_tdata);
                rx_last.push_back(out_tlast);
            end
            if (cyc >= 3 && cyc <= 7) begin
                check($sformatf("stall c%0d tready", cyc), in_tready, 4'b0000);
                check($sformatf("stall c%0d out_tvalid", cyc), out_tvalid, 1'b1);
                check($sformatf("stall c%0d hold data", cyc), out_tdata, 8'hB1);
            end
            if (acc) idx++;
        end
        check("stall beat count", rx_data.size(), 4);
        for (int k = 0; k < 4 && k < rx_data.size(); k++) begin
            check($sformatf("stall beat%0d data", k), rx_data[k], bp_beats[k]);
            check($sformatf("stall beat%0d tlast", k), rx_last[k], (k == 3));
        end

        // Port 1 stalls tvalid mid-frame while port 3 keeps requesting
        do_reset();
        idx  = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 12 && !done; cyc++) begin
            next_cycle();
            in_tvalid[1]    = (idx < 3) && !(cyc >= 3 && cyc <= 5);
            in_tdata[15:8]  = 8'hC0 + 8'(idx);
            in_tlast[1]     = (idx == 2);
            in_tvalid[3]    = 1'b1;
            in_tlast[3]     = 1'b1;
            in_tdata[31:24] = 8'hD3;
            @(negedge clk);
            if (cyc >= 1) begin
                check($sformatf("hold c%0d grant", cyc), grant, 2'd1);
                check($sformatf("hold c%0d grant_valid", cyc), grant_valid, 1'b1);
            end
            check($sformatf("hold c%0d port3 tready", cyc), in_tready[3], 1'b0);
            if (in_tready[1] && in_tvalid[1]) begin
                if (idx == 2) done = 1'b1;
                idx++;
            end
        end
        check("hold frame completed", done, 1'b1);
        next_cycle();
        in_tvalid[1] = 1'b0;
        @(negedge clk);
        check("hold boundary grant_valid", grant_valid, 1'b0);
        check("hold boundary tready", in_tready, 4'b0000);
        next_cycle();
        @(negedge clk);
        check("hold next grant", grant, 2'd3);
        check("hold next grant_valid", grant_valid, 1'b1);
        check("hold next tready", in_tready, 4'b1000);

        // Reset pulsed during the second beat of a frame
        do_reset();
        next_cycle();
        in_tvalid = 4'b0001;
        in_tlast  = 4'b0001;
        in_tdata  = 32'h0000_00E0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("rst first frame tready", in_tready, 4'b0001);
        next_cycle();
        in_tvalid = 4'b0000;
        in_tlast  = 4'b0000;
        @(negedge clk);
        next_cycle();
        in_tvalid = 4'b0010;
        in_tdata  = 32'h0000_F000;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        next_cycle();
        in_tdata  = 32'h0000_F100;
        in_tuser  = 4'b0010;
        @(negedge clk);
        check("rst pre out_tvalid", out_tvalid, 1'b1);
        check("rst pre out_tdata", out_tdata, 8'hF0);
        check("rst pre grant", grant, 2'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst async out_tvalid", out_tvalid, 1'b0);
        check("rst async out_tdata", out_tdata, 8'h00);
        check("rst async out_tlast", out_tlast, 1'b0);
        check("rst async out_tuser", out_tuser, 1'b0);
        check("rst async grant", grant, 2'd0);
        check("rst async grant_valid", grant_valid, 1'b0);
        check("rst async tready", in_tready, 4'b0000);
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        in_tvalid = 4'b0101;
        in_tlast  = 4'b0101;
        in_tdata  = 32'h00C2_00C0;
        @(negedge clk);
        check("rst restart idle grant_valid", grant_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check("rst restart grant", grant, 2'd0);
        check("rst restart grant_valid", grant_valid, 1'b1);
        check("rst restart tready", in_tready, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
